// File: rtl/viterbi_pkg.sv
// Shared Viterbi definitions: trellis size, branch-symbol parity and PM saturation helpers.
package viterbi_pkg;

    localparam int G0_DEFAULT       = 32'sd7;
    localparam int G1_DEFAULT       = 32'sd5;
    localparam int PM_WIDTH_DEFAULT = 32'sd8;

    function automatic int num_states(input int k);
        return 32'sd1 <<< (k - 32'sd1);
    endfunction

    // Encoder output {X,Y} for register contents {p,in}; the MSB of each generator taps the oldest bit.
    function automatic logic [1:0] branch_sym(input logic [31:0] g0, input logic [31:0] g1,
                                              input logic [31:0] reg_bits);
        return {^(g0 & reg_bits), ^(g1 & reg_bits)};
    endfunction

    function automatic logic [31:0] pm_sat(input int w);
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/acs_node.sv
// One trellis destination: add both branch metrics, saturate on carry, keep the smaller candidate.
module acs_node
    import viterbi_pkg::*;
#(
    parameter int BM_WIDTH = 2,
    parameter int PM_WIDTH = 8
) (
    input  logic [PM_WIDTH-1:0] pm_0,
    input  logic [PM_WIDTH-1:0] pm_1,
    input  logic [BM_WIDTH-1:0] bm_0,
    input  logic [BM_WIDTH-1:0] bm_1,
    output logic [PM_WIDTH-1:0] new_pm,
    output logic                decision
);

    localparam int SUM_W = PM_WIDTH + 1;
    localparam logic [PM_WIDTH-1:0] PM_MAX = PM_WIDTH'(pm_sat(PM_WIDTH));

    logic [SUM_W-1:0]    sum_0_s;
    logic [SUM_W-1:0]    sum_1_s;
    logic [PM_WIDTH-1:0] cand_0_s;
    logic [PM_WIDTH-1:0] cand_1_s;

    // Add with one guard bit, then clamp to all-ones on carry
    always_comb begin
        sum_0_s  = {1'b0, pm_0} + SUM_W'(bm_0);
        sum_1_s  = {1'b0, pm_1} + SUM_W'(bm_1);
        cand_0_s = sum_0_s[PM_WIDTH] ? PM_MAX : sum_0_s[PM_WIDTH-1:0];
        cand_1_s = sum_1_s[PM_WIDTH] ? PM_MAX : sum_1_s[PM_WIDTH-1:0];
    end

    // Ties favour the upper predecessor
    always_comb begin
        if (cand_0_s <= cand_1_s) begin
            new_pm   = cand_0_s;
            decision = 1'b0;
        end else begin
            new_pm   = cand_1_s;
            decision = 1'b1;
        end
    end

endmodule

// File: rtl/acs_pm_unit.sv
// Registered ACS array with path-metric storage, frame-start init, MSB-clear normalisation
// and best-state tracking for a rate-1/2 shift-left trellis.
module acs_pm_unit
    import viterbi_pkg::*;
#(
    parameter int K        = 3,
    parameter int G0       = G0_DEFAULT,
    parameter int G1       = G1_DEFAULT,
    parameter int BM_WIDTH = 2,
    parameter int PM_WIDTH = PM_WIDTH_DEFAULT,
    parameter int INIT_PM  = 64,
    parameter int NORM_EN  = 1
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                valid_i,
    input  logic                                start_i,
    input  logic [4*BM_WIDTH-1:0]               bm_i,
    output logic [num_states(K)-1:0]            dec_bits_o,
    output logic                                dec_valid_o,
    output logic [num_states(K)*PM_WIDTH-1:0]   pm_o,
    output logic [K-2:0]                        best_state_o,
    output logic                                norm_o
);

    localparam int NS   = num_states(K);
    localparam int SW   = K - 1;
    localparam int PM_V = NS * PM_WIDTH;

    function automatic logic [PM_V-1:0] init_vec();
        logic [PM_V-1:0] v;
        v = '0;
        for (int d = 1; d < NS; d++) begin
            v[d*PM_WIDTH +: PM_WIDTH] = PM_WIDTH'(INIT_PM);
        end
        return v;
    endfunction

    localparam logic [PM_V-1:0] PM_INIT = init_vec();

    logic [PM_V-1:0]     pm_r;
    logic [PM_V-1:0]     old_pm_s;
    logic [PM_V-1:0]     acs_pm_s;
    logic [PM_V-1:0]     new_pm_s;
    logic [NS-1:0]       dec_s;
    logic [NS-1:0]       msb_s;
    logic                norm_s;
    logic                less_s;
    logic [SW-1:0]       best_s;
    logic [PM_WIDTH-1:0] best_val_s;

    // Frame start feeds the init metrics so stale registers never reach the ACS
    always_comb begin
        if (start_i) begin
            old_pm_s = PM_INIT;
        end else begin
            old_pm_s = pm_r;
        end
    end

    for (genvar d = 0; d < NS; d++) begin : g_node
        localparam int P0   = d / 32'sd2;
        localparam int P1   = P0 + NS / 32'sd2;
        localparam int IN   = d % 32'sd2;
        localparam int SYM0 = int'(branch_sym(G0, G1, 32'(P0 * 32'sd2 + IN)));
        localparam int SYM1 = int'(branch_sym(G0, G1, 32'(P1 * 32'sd2 + IN)));

        acs_node #(
            .BM_WIDTH (BM_WIDTH),
            .PM_WIDTH (PM_WIDTH)
        ) u_acs_node (
            .pm_0     (old_pm_s[P0*PM_WIDTH +: PM_WIDTH]),
            .pm_1     (old_pm_s[P1*PM_WIDTH +: PM_WIDTH]),
            .bm_0     (bm_i[SYM0*BM_WIDTH +: BM_WIDTH]),
            .bm_1     (bm_i[SYM1*BM_WIDTH +: BM_WIDTH]),
            .new_pm   (acs_pm_s[d*PM_WIDTH +: PM_WIDTH]),
            .decision (dec_s[d])
        );
    end

    // Normalise only when every survivor has crossed half range
    always_comb begin
        msb_s = '0;
        for (int d = 0; d < NS; d++) begin
            msb_s[d] = acs_pm_s[d*PM_WIDTH + PM_WIDTH - 1];
        end
        norm_s = (NORM_EN != 32'sd0) && (&msb_s);
    end

    // Clear every MSB together so relative metrics are preserved
    always_comb begin
        new_pm_s = acs_pm_s;
        if (norm_s) begin
            for (int d = 0; d < NS; d++) begin
                new_pm_s[d*PM_WIDTH + PM_WIDTH - 1] = 1'b0;
            end
        end else begin
            new_pm_s = acs_pm_s;
        end
    end

    // Strict less-than scan keeps the lowest index on ties
    always_comb begin
        best_s     = '0;
        best_val_s = new_pm_s[PM_WIDTH-1:0];
        less_s     = 1'b0;
        for (int d = 1; d < NS; d++) begin
            less_s     = new_pm_s[d*PM_WIDTH +: PM_WIDTH] < best_val_s;
            best_val_s = less_s ? new_pm_s[d*PM_WIDTH +: PM_WIDTH] : best_val_s;
            best_s     = less_s ? SW'(d) : best_s;
        end
    end

    // Path-metric and decision registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pm_r         <= PM_INIT;
            dec_bits_o   <= '0;
            dec_valid_o  <= 1'b0;
            best_state_o <= '0;
            norm_o       <= 1'b0;
        end else if (valid_i) begin
            pm_r         <= new_pm_s;
            dec_bits_o   <= dec_s;
            dec_valid_o  <= 1'b1;
            best_state_o <= best_s;
            norm_o       <= norm_s;
        end else begin
            dec_valid_o  <= 1'b0;
            norm_o       <= 1'b0;
            if (start_i) begin
                pm_r         <= PM_INIT;
                best_state_o <= '0;
            end
        end
    end

    assign pm_o = pm_r;

endmodule
